// File: rtl/ac_match_reporter_if.sv
// ---------------------------------------------------------------------------
// ac_match_reporter_if
//   Bundles the ac_match_reporter handshakes:
//     state_in/state_valid/state_ready  walker state stream (into the reporter)
//     tbl_we/tbl_addr/tbl_data          output-table write port
//     match_valid/match_ready           match event handshake (out of reporter)
//     match_id/match_pos                pattern index / end position of event
//     match_count                       delivered match events (0 if not built)
//   Modports: master = walker/software/consumer side, slave = reporter side.
// ---------------------------------------------------------------------------
interface ac_match_reporter_if #(
  parameter int unsigned STATE_W = 8,
  parameter int unsigned NPAT    = 8,
  parameter int unsigned POS_W   = 16
);
  localparam int unsigned ID_W = (NPAT > 1) ? $clog2(NPAT) : 1;

  logic [STATE_W-1:0] state_in;
  logic               state_valid;
  logic               state_ready;

  logic               tbl_we;
  logic [STATE_W-1:0] tbl_addr;
  logic [NPAT-1:0]    tbl_data;

  logic               match_valid;
  logic               match_ready;
  logic [ID_W-1:0]    match_id;
  logic [POS_W-1:0]   match_pos;
  logic [15:0]        match_count;

  modport master (
    output state_in, state_valid, tbl_we, tbl_addr, tbl_data, match_ready,
    input  state_ready, match_valid, match_id, match_pos, match_count
  );

  modport slave (
    input  state_in, state_valid, tbl_we, tbl_addr, tbl_data, match_ready,
    output state_ready, match_valid, match_id, match_pos, match_count
  );
endinterface

// File: rtl/ac_match_reporter.sv
// ---------------------------------------------------------------------------
// ac_match_reporter
//   Aho-Corasick output-function stage. Each accepted walker state is looked
//   up in a loadable table of pattern masks; non-empty masks are buffered in a
//   small FIFO together with the character position, then serialized into one
//   match event per set bit (lowest pattern index first).
//
// Ports
//   clk_i    clock, all updates on the rising edge
//   rst_ni   asynchronous active-low reset (table contents are retained)
//   en_i     scan enable, gates state_ready only
//   bus      ac_match_reporter_if.slave: state stream, table write port,
//            match event stream and match_count
//
// Build option
//   AC_MATCH_COUNT_EN  when defined, match_count counts delivered events and
//                      saturates at 16'hFFFF; otherwise it is tied to zero.
//
// Pipeline
//   accept edge  : table read (old data on same-address write), pos captured
//   +1 edge      : S1 {mask, pos, valid}
//   +2 edge      : non-zero mask pushed into the hit FIFO
//   +3 edge      : serializer loads the work register, event visible
// ---------------------------------------------------------------------------
module ac_match_reporter #(
  parameter int unsigned STATE_W    = 8,
  parameter int unsigned NPAT       = 8,
  parameter int unsigned POS_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  ac_match_reporter_if.slave  bus
);

  localparam int unsigned ID_W      = (NPAT > 1) ? $clog2(NPAT) : 1;
  localparam int unsigned TBL_DEPTH = 1 << STATE_W;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned OCC_W     = CNT_W + 1;

  typedef enum logic {
    IDLE,
    EMIT
  } ser_state_e;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [ID_W-1:0] lsb_idx(input logic [NPAT-1:0] m);
    logic [ID_W-1:0] idx;
    logic            found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NPAT; i++) begin
      if (m[i] && !found) begin
        idx   = ID_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // -------------------------------------------------------------------------
  // Output table and read stage
  // -------------------------------------------------------------------------
  logic [NPAT-1:0]  tbl_q [TBL_DEPTH];

  logic             run_q;       // low while in reset and for the first edge after
  logic             state_ready;
  logic             accept;

  logic [POS_W-1:0] pos_q, pos_d;
  logic             rd_valid_q;  // accept in flight (table data being read)
  logic [NPAT-1:0]  rd_mask_q;
  logic [POS_W-1:0] rd_pos_q;

  logic             s1_valid_q;
  logic [NPAT-1:0]  s1_mask_q;
  logic [POS_W-1:0] s1_pos_q;

  assign accept = bus.state_valid && state_ready;
  assign pos_d  = pos_q + POS_W'(1);

  // Table has no reset so it survives rst_ni. The read samples tbl_q before
  // this edge's write lands, giving old data on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (bus.tbl_we) begin
      tbl_q[bus.tbl_addr] <= bus.tbl_data;
    end
    if (accept) begin
      rd_mask_q <= tbl_q[bus.state_in];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      pos_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_pos_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_mask_q  <= '0;
      s1_pos_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      rd_valid_q <= accept;
      if (accept) begin
        rd_pos_q <= pos_q;
        pos_q    <= pos_d;
      end
      s1_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        s1_mask_q <= rd_mask_q;
        s1_pos_q  <= rd_pos_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hit FIFO
  // -------------------------------------------------------------------------
  logic [NPAT-1:0]  fifo_mask_q [FIFO_DEPTH];
  logic [POS_W-1:0] fifo_pos_q  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             fifo_nonempty;
  logic             push;
  logic             pop;
  logic [NPAT-1:0]  head_mask;
  logic [POS_W-1:0] head_pos;
  logic [OCC_W-1:0] occ;

  assign push          = s1_valid_q && (s1_mask_q != '0);
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign head_mask     = fifo_mask_q[rd_ptr_q];
  assign head_pos      = fifo_pos_q[rd_ptr_q];

  // Everything already accepted but not yet in the work register counts
  // against FIFO space, so a full pipeline can never overflow the FIFO.
  assign occ = {1'b0, fifo_cnt_q}
             + OCC_W'(s1_valid_q)
             + OCC_W'(rd_valid_q);
  assign state_ready = run_q && en_i && (occ < OCC_W'(FIFO_DEPTH));
  assign bus.state_ready = state_ready;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mask_q[wr_ptr_q] <= s1_mask_q;
      fifo_pos_q[wr_ptr_q]  <= s1_pos_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Serializer
  // -------------------------------------------------------------------------
  ser_state_e       state_q;
  logic [NPAT-1:0]  wmask_q;
  logic [NPAT-1:0]  wmask_clr;    // work mask with the current bit removed
  logic             match_valid_q;
  logic [ID_W-1:0]  match_id_q;
  logic [POS_W-1:0] match_pos_q;

  assign wmask_clr = wmask_q & (wmask_q - NPAT'(1));

  // Pop on load from IDLE, or back-to-back reload when the last bit of the
  // current mask is consumed and another hit is waiting.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = fifo_nonempty;
      EMIT:    pop = bus.match_ready && (wmask_clr == '0) && fifo_nonempty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wmask_q       <= '0;
      match_valid_q <= 1'b0;
      match_id_q    <= '0;
      match_pos_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fifo_nonempty) begin
            state_q       <= EMIT;
            wmask_q       <= head_mask;
            match_valid_q <= 1'b1;
            match_id_q    <= lsb_idx(head_mask);
            match_pos_q   <= head_pos;
          end
        end
        EMIT: begin
          if (bus.match_ready) begin
            if (wmask_clr != '0) begin
              wmask_q    <= wmask_clr;
              match_id_q <= lsb_idx(wmask_clr);
            end else if (fifo_nonempty) begin
              wmask_q     <= head_mask;
              match_id_q  <= lsb_idx(head_mask);
              match_pos_q <= head_pos;
            end else begin
              state_q       <= IDLE;
              wmask_q       <= '0;
              match_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          match_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.match_valid = match_valid_q;
  assign bus.match_id    = match_id_q;
  assign bus.match_pos   = match_pos_q;

  // -------------------------------------------------------------------------
  // Delivered-event counter
  // -------------------------------------------------------------------------
`ifdef AC_MATCH_COUNT_EN
  logic [15:0] mcount_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcount_q <= '0;
    end else if (match_valid_q && bus.match_ready && (mcount_q != '1)) begin
      mcount_q <= mcount_q + 16'd1;
    end
  end

  assign bus.match_count = mcount_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_ac_match_reporter.sv
module tb_ac_match_reporter;

  logic clk;
  logic rst_n;
  logic en;

  ac_match_reporter_if #(.STATE_W(8), .NPAT(8), .POS_W(16)) bus ();

  ac_match_reporter #(
    .STATE_W(8),
    .NPAT(8),
    .POS_W(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] pos;
  } ev_t;

  int          n_chk;
  int          n_err;
  int          cyc;
  logic [7:0]  mtbl [256];
  logic [15:0] mpos;
  int unsigned mcount;
  ev_t         q[$];        // events promised by the model, in delivery order
  ev_t         log_q[$];    // events observed on the DUT outputs
  int          log_cyc[$];
  bit          acc_flag;
  int          acc_total;
  int          acc_cyc_last;
  int          first_mv_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_count();
`ifdef AC_MATCH_COUNT_EN
    return int'(mcount);
`else
    return 0;
`endif
  endfunction

  // One clock cycle: compare outputs at the falling edge against the model,
  // then account for what the coming rising edge will accept/write.
  task automatic step();
    logic [7:0] m;
    ev_t        e;
    @(negedge clk);
    cyc++;
    acc_flag = 1'b0;
    chk("match_count", 32'(bus.match_count), 32'(exp_count()));
    if (!en) chk("ready_gated_by_en", 32'(bus.state_ready), 32'd0);
    if (bus.match_valid === 1'b1) begin
      if (first_mv_cyc < 0) first_mv_cyc = cyc;
      if (q.size() == 0) begin
        chk("spurious_event", 32'(bus.match_valid), 32'd0);
      end else begin
        chk("match_id", 32'(bus.match_id), 32'(q[0].id));
        chk("match_pos", 32'(bus.match_pos), 32'(q[0].pos));
        if (bus.match_ready) begin
          e.id  = bus.match_id;
          e.pos = bus.match_pos;
          log_q.push_back(e);
          log_cyc.push_back(cyc);
          void'(q.pop_front());
          if (mcount < 65535) mcount++;
        end
      end
    end
    if (bus.state_valid && bus.state_ready) begin
      m = mtbl[bus.state_in];
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          e.id  = 3'(i);
          e.pos = mpos;
          q.push_back(e);
        end
      end
      mpos         = mpos + 16'd1;
      acc_flag     = 1'b1;
      acc_total++;
      acc_cyc_last = cyc;
    end
    if (bus.tbl_we) mtbl[bus.tbl_addr] = bus.tbl_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.state_valid = 1'b0;
    bus.tbl_we      = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_match_valid", 32'(bus.match_valid), 32'd0);
    chk("rst_state_ready", 32'(bus.state_ready), 32'd0);
    chk("rst_match_id", 32'(bus.match_id), 32'd0);
    chk("rst_match_pos", 32'(bus.match_pos), 32'd0);
    chk("rst_match_count", 32'(bus.match_count), 32'd0);
    q.delete();
    mpos   = '0;
    mcount = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s);
    bus.state_in    = s;
    bus.state_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (acc_flag) break;
    end
    chk("send_accepted", 32'(acc_flag), 32'd1);
    bus.state_valid = 1'b0;
  endtask

  task automatic drain();
    bus.state_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (q.size() == 0) break;
      step();
    end
    chk("drain_complete", 32'(q.size()), 32'd0);
    repeat (6) step();
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc5;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    acc_total    = 0;
    first_mv_cyc = -1;
    for (int a = 0; a < 256; a++) mtbl[a] = 'x;
    rst_n           = 1'b1;
    en              = 1'b1;
    bus.state_in    = '0;
    bus.state_valid = 1'b0;
    bus.tbl_we      = 1'b0;
    bus.tbl_addr    = '0;
    bus.tbl_data    = '0;
    bus.match_ready = 1'b1;
    #3;
    do_reset();

    // Table load with scanning disabled.
    en = 1'b0;
    bus.tbl_we = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bus.tbl_addr = 8'(a);
      case (a)
        3:       bus.tbl_data = 8'h01;
        4:       bus.tbl_data = 8'h10;
        5:       bus.tbl_data = 8'h01;
        9:       bus.tbl_data = 8'hA4;
        default: bus.tbl_data = 8'h00;
      endcase
      step();
    end
    bus.tbl_we = 1'b0;
    en = 1'b1;

    // Single hit on the third state, latency from accept.
    clear_log();
    send(8'd0);
    send(8'd0);
    first_mv_cyc = -1;
    send(8'd5);
    acc5 = acc_cyc_last;
    drain();
    chk("t1_latency", 32'(first_mv_cyc - acc5), 32'd4);
    chk("t1_events", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      chk("t1_id", 32'(log_q[0].id), 32'd0);
      chk("t1_pos", 32'(log_q[0].pos), 32'd2);
    end

    // Multi-bit mask expands into consecutive events.
    do_reset();
    clear_log();
    send(8'd9);
    drain();
    chk("t2_events", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t2_id0", 32'(log_q[0].id), 32'd2);
      chk("t2_id1", 32'(log_q[1].id), 32'd5);
      chk("t2_id2", 32'(log_q[2].id), 32'd7);
      chk("t2_pos2", 32'(log_q[2].pos), 32'd0);
      chk("t2_back_to_back", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    end
`ifdef AC_MATCH_COUNT_EN
    chk("t2_count", 32'(bus.match_count), 32'd3);
`else
    chk("t2_count", 32'(bus.match_count), 32'd0);
`endif

    // Backpressure: work register plus full FIFO, then ordered release.
    do_reset();
    clear_log();
    acc_total = 0;
    bus.match_ready = 1'b0;
    bus.state_in    = 8'd3;
    bus.state_valid = 1'b1;
    repeat (20) step();
    chk("t3_accepts", 32'(acc_total), 32'd5);
    chk("t3_ready_low", 32'(bus.state_ready), 32'd0);
    bus.state_valid = 1'b0;
    bus.match_ready = 1'b1;
    drain();
    chk("t3_events", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < log_q.size() && i < 5; i++) begin
      chk("t3_pos_order", 32'(log_q[i].pos), 32'(i));
      chk("t3_no_gap", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
    end

    // Position counter wrap.
    do_reset();
    clear_log();
    acc_total = 0;
    bus.state_in    = 8'd0;
    bus.state_valid = 1'b1;
    for (int k = 0; k < 70000 && acc_total < 65534; k++) step();
    bus.state_in = 8'd5;
    for (int k = 0; k < 100 && acc_total < 65537; k++) step();
    bus.state_valid = 1'b0;
    drain();
    chk("t4_events", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t4_pos0", 32'(log_q[0].pos), 32'h0000_FFFE);
      chk("t4_pos1", 32'(log_q[1].pos), 32'h0000_FFFF);
      chk("t4_pos2", 32'(log_q[2].pos), 32'h0000_0000);
    end

    // Reset while emitting with FIFO entries pending.
    do_reset();
    clear_log();
    bus.match_ready = 1'b0;
    send(8'd9);
    send(8'd3);
    send(8'd3);
    repeat (4) step();
    chk("t5_emit_before_reset", 32'(bus.match_valid), 32'd1);
    do_reset();
    bus.match_ready = 1'b1;
    clear_log();
    send(8'd5);
    drain();
    chk("t5_events", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) begin
      chk("t5_id", 32'(log_q[0].id), 32'd0);
      chk("t5_pos", 32'(log_q[0].pos), 32'd0);
    end

    // Table write colliding with a read of the same address.
    do_reset();
    clear_log();
    chk("t6_ready", 32'(bus.state_ready), 32'd1);
    bus.state_in    = 8'd4;
    bus.state_valid = 1'b1;
    bus.tbl_we      = 1'b1;
    bus.tbl_addr    = 8'd4;
    bus.tbl_data    = 8'h02;
    step();
    chk("t6_accept", 32'(acc_flag), 32'd1);
    bus.tbl_we      = 1'b0;
    bus.state_valid = 1'b0;
    send(8'd4);
    drain();
    chk("t6_events", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t6_old_id", 32'(log_q[0].id), 32'd4);
      chk("t6_new_id", 32'(log_q[1].id), 32'd1);
      chk("t6_new_pos", 32'(log_q[1].pos), 32'd1);
    end

    // Randomized traffic: sparse masks, table updates during scan,
    // toggling enable and consumer backpressure.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      bus.tbl_we   = 1'b1;
      bus.tbl_addr = 8'(a);
      bus.tbl_data = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom);
      step();
    end
    bus.tbl_we = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      bus.state_valid = 1'($urandom % 2);
      bus.state_in    = 8'($urandom % 16);
      en              = (($urandom % 8) != 0);
      bus.match_ready = (($urandom % 4) != 0);
      bus.tbl_we      = (($urandom % 16) == 0);
      bus.tbl_addr    = 8'($urandom % 16);
      bus.tbl_data    = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      step();
    end
    bus.tbl_we      = 1'b0;
    bus.match_ready = 1'b1;
    en              = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
